// File: rtl/dtw_accel_m00_axis_pkg.sv
// Shared definitions for the DTW accelerator stream blocks: FSM encoding,
// counter widths and the FIFO entry layout ({last, data}, last bit at the MSB).
package dtw_accel_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int PKT_CNT_W = 16;

  // Number of bits needed to hold the given value (clogb2(7) = 3, clogb2(1) = 1).
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((value >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

  // Pointer width for the default 8-entry buffer.
  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_PTR_W      = clogb2(DEFAULT_FIFO_DEPTH - 1);

  // One stored entry is the data word plus the packet-end flag on top.
  function automatic int entry_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/dtw_accel_m00_axis_if.sv
// AXI4-Stream bus bundle between the DTW result transmitter and the DMA.
interface dtw_accel_m00_axis_if #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32
);
  logic                              TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] TSTRB;
  logic                              TLAST;
  logic                              TREADY;

  modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/dtw_accel_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head entry.
// Shared by the S00 sink and the M00 transmitter.
module dtw_accel_sync_fifo
  import dtw_accel_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wren,
  input  logic [WIDTH-1:0] din,
  input  logic             rden,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = clogb2(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wren && !full;
  assign pop   = rden && !empty;
  assign dout  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/dtw_accel_m00_axis.sv
// AXI4-Stream master end of the DTW accelerator: buffers result words from the
// core, cuts them into packets (TLAST) and streams them to the DMA.
// Optional macro DTW_ACCEL_M_AXIS_SKID_EN adds a 2-entry output register slice.
module dtw_accel_m00_axis
  import dtw_accel_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 8,
  parameter int PACKET_LEN           = 8
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            dtw_fifo_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din,
  input  logic                            dtw_fifo_last,
  output logic                            dtw_fifo_full,
  output logic                            dtw_overflow,
  output logic [PKT_CNT_W-1:0]            pkt_count,
  dtw_accel_m00_axis_if.master            m_axis
);
  localparam int W      = C_M_AXIS_TDATA_WIDTH;
  localparam int EW     = entry_width(W);
  localparam int WCNT_W = (clogb2(PACKET_LEN - 1) < 1) ? 1 : clogb2(PACKET_LEN - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic              overflow_q;
  logic [PKT_CNT_W-1:0] pkt_q;

  logic          fifo_full, fifo_empty, fifo_rden;
  logic [EW-1:0] fifo_dout;
  logic          last_bit, push_ok;
  logic          out_valid, out_fire, out_last;
  logic [W-1:0]  out_data;

  assign push_ok  = dtw_fifo_wren && !fifo_full;
  assign last_bit = dtw_fifo_last || (wcnt_q == WCNT_W'(PACKET_LEN - 1));
  assign out_fire = out_valid && m_axis.TREADY;

  assign dtw_fifo_full = fifo_full;
  assign dtw_overflow  = overflow_q;
  assign pkt_count     = pkt_q;

  dtw_accel_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst   (M_AXIS_ARESET),
    .wren  (dtw_fifo_wren),
    .din   ({last_bit, dtw_fifo_din}),
    .rden  (fifo_rden),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Word counter, sticky overflow flag and completed-packet counter.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
      pkt_q      <= '0;
    end else begin
      if (push_ok) wcnt_q <= last_bit ? '0 : wcnt_q + 1'b1;
      if (dtw_fifo_wren && fifo_full) overflow_q <= 1'b1;
      if (out_fire && out_last) pkt_q <= pkt_q + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) state_q <= IDLE;
    else               state_q <= state_d;
  end

`ifdef DTW_ACCEL_M_AXIS_SKID_EN
  logic [EW-1:0] s0_q, s0_d, s1_q, s1_d;
  logic          s0_v_q, s0_v_d, s1_v_q, s1_v_d;

  // The slice pulls from the FIFO whenever its second slot is free, independent of TREADY.
  assign fifo_rden = !fifo_empty && !s1_v_q;

  // Next-state: SEND while anything sits in the slice or is being loaded into it.
  always_comb begin
    state_d = (s0_v_q || s1_v_q || fifo_rden) ? SEND : IDLE;
  end

  // Slice update: retire the head on a handshake, then append any word loaded from the FIFO.
  always_comb begin
    s0_d   = s0_q;
    s0_v_d = s0_v_q;
    s1_d   = s1_q;
    s1_v_d = s1_v_q;
    if (out_fire) begin
      s0_d   = s1_q;
      s0_v_d = s1_v_q;
      s1_v_d = 1'b0;
    end
    if (fifo_rden) begin
      if (!s0_v_d) begin
        s0_d   = fifo_dout;
        s0_v_d = 1'b1;
      end else begin
        s1_d   = fifo_dout;
        s1_v_d = 1'b1;
      end
    end
  end

  // Slice registers; only the valid bits need reset.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      s0_v_q <= 1'b0;
      s1_v_q <= 1'b0;
    end else begin
      s0_v_q <= s0_v_d;
      s1_v_q <= s1_v_d;
    end
    s0_q <= s0_d;
    s1_q <= s1_d;
  end

  // Outputs come straight from the slice head flops.
  always_comb begin
    out_valid = s0_v_q;
    out_data  = s0_q[W-1:0];
    out_last  = s0_q[EW-1];
  end
`else
  // Pop the FIFO head exactly when the downstream accepts the beat.
  assign fifo_rden = out_fire;

  // Next-state: start on buffered data, return to IDLE after the TLAST beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (out_fire && fifo_dout[EW-1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs fall through from the FIFO head while sending.
  always_comb begin
    out_valid = (state_q == SEND) && !fifo_empty;
    out_data  = fifo_dout[W-1:0];
    out_last  = fifo_dout[EW-1];
  end
`endif

  // Drive the stream bus.
  always_comb begin
    m_axis.TVALID = out_valid;
    m_axis.TDATA  = out_data;
    m_axis.TLAST  = out_last;
    m_axis.TSTRB  = '1;
  end
endmodule
